// File: rtl/evt_burst_gen.sv
// Burst event transmitter: emits N single-cycle pulses on evt_out spaced by G idle
// cycles after a valid/ready request, then strobes done_out for one cycle.
module evt_burst_gen #(
  parameter int unsigned MAX_COUNT = 1000,
  parameter int unsigned MAX_GAP   = 256,
  localparam int unsigned CW = $clog2(MAX_COUNT),
  localparam int unsigned GW = $clog2(MAX_GAP)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          req_valid_in,
  output logic          req_ready_out,
  input  logic [CW-1:0] req_count_in,
  input  logic [GW-1:0] req_gap_in,
  input  logic          abort_in,
  output logic          evt_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          aborted_out,
  output logic [CW-1:0] sent_out
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] sent_q;
  logic [GW-1:0] g_q;
  logic [GW-1:0] gap_cnt_q;
  logic          aborted_q;
  logic [CW-1:0] sent_inc;

  assign sent_inc = sent_q + CW'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      n_q       <= '0;
      g_q       <= '0;
      gap_cnt_q <= '0;
      sent_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_in) begin
            n_q       <= req_count_in;
            g_q       <= req_gap_in;
            sent_q    <= '0;
            aborted_q <= 1'b0;
            state_q   <= (req_count_in == '0) ? StDone : StPulse;
          end
        end
        StPulse: begin
          sent_q <= sent_inc;
          // Normal completion takes priority over a coincident abort.
          if (sent_inc == n_q) begin
            state_q <= StDone;
          end else if (abort_in) begin
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else if (g_q == '0) begin
            state_q <= StPulse;
          end else begin
            gap_cnt_q <= g_q;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (abort_in) begin
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else if (gap_cnt_q == GW'(1)) begin
            state_q <= StPulse;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_out = (state_q == StIdle);
  assign evt_out       = (state_q == StPulse);
  assign busy_out      = (state_q == StPulse) || (state_q == StGap);
  assign done_out      = (state_q == StDone);
  assign aborted_out   = (state_q == StDone) && aborted_q;
  assign sent_out      = sent_q;

endmodule
